// File: rtl/yc2ycbcr.sv
// yc2ycbcr: rebuilds 4:4:4 YCbCr from a 4:2:2 YC stream.
// Each Cb/Cr pair is presented on both pixels of the pair. Chroma is only
// selected, never computed. Every output lags its input by exactly two clocks.
module yc2ycbcr #(
  parameter int C_DATA_WIDTH = 10,
  parameter bit C_CR_FIRST   = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    VS_in,
  input  logic                    HS_in,
  input  logic                    DE_in,
  input  logic [C_DATA_WIDTH-1:0] Y_in,
  input  logic [C_DATA_WIDTH-1:0] C_in,
  output logic                    VS_out,
  output logic                    HS_out,
  output logic                    DE_out,
  output logic [C_DATA_WIDTH-1:0] Y_out,
  output logic [C_DATA_WIDTH-1:0] Cb_out,
  output logic [C_DATA_WIDTH-1:0] Cr_out
);

  // Chroma mid-scale. It fills the missing partner of a trailing odd pixel.
  localparam logic [C_DATA_WIDTH-1:0] NEUTRAL = {1'b1, {(C_DATA_WIDTH-1){1'b0}}};

  // Phase of the sample currently on the input. Zero marks the first word of a pair.
  logic                    ph_q;

  // Stage A: the incoming pixel, delayed by one clock
  logic                    vs_a_q, hs_a_q, de_a_q, ph_a_q;
  logic [C_DATA_WIDTH-1:0] y_a_q, c_a_q;

  // First chroma of the pair, held for the pair's second pixel
  logic [C_DATA_WIDTH-1:0] hold_q, hold_d;

  // Output stage
  logic                    vs_q, hs_q, de_q;
  logic [C_DATA_WIDTH-1:0] y_q, cb_q, cr_q;
  logic [C_DATA_WIDTH-1:0] first_d, second_d, cb_d, cr_d;

  // Phase tracking and stage A capture.
  // NOTE: sequential state uses non-blocking (<=), so every register samples
  // pre-edge values and the result does not depend on the order of statements.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph_q   <= 1'b0;
      vs_a_q <= 1'b0;
      hs_a_q <= 1'b0;
      de_a_q <= 1'b0;
      ph_a_q <= 1'b0;
      y_a_q  <= '0;
      c_a_q  <= '0;
    end else begin
      ph_q   <= DE_in ? ~ph_q : 1'b0;
      vs_a_q <= VS_in;
      hs_a_q <= HS_in;
      de_a_q <= DE_in;
      ph_a_q <= ph_q;
      y_a_q  <= Y_in;
      c_a_q  <= C_in;
    end
  end

  // Chroma selection from stage A, with a one-pixel look-ahead at the live input
  always_comb begin
    // NOTE: assigning a default to every output before any branch means no
    // path leaves a signal unassigned, so no latch can be inferred.
    first_d  = c_a_q;
    second_d = c_a_q;
    hold_d   = hold_q;
    if (de_a_q) begin
      if (!ph_a_q) begin
        first_d  = c_a_q;
        second_d = DE_in ? C_in : NEUTRAL;
        hold_d   = c_a_q;
      end else begin
        first_d  = hold_q;
        second_d = c_a_q;
      end
    end
    cb_d = C_CR_FIRST ? second_d : first_d;
    cr_d = C_CR_FIRST ? first_d  : second_d;
  end

  // Output registers and the pair hold register. Syncs reset to their idle-high level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vs_q   <= 1'b1;
      hs_q   <= 1'b1;
      de_q   <= 1'b0;
      y_q    <= '0;
      cb_q   <= '0;
      cr_q   <= '0;
      hold_q <= '0;
    end else begin
      vs_q   <= vs_a_q;
      hs_q   <= hs_a_q;
      de_q   <= de_a_q;
      y_q    <= y_a_q;
      cb_q   <= cb_d;
      cr_q   <= cr_d;
      hold_q <= hold_d;
    end
  end

  assign VS_out = vs_q;
  assign HS_out = hs_q;
  assign DE_out = de_q;
  assign Y_out  = y_q;
  assign Cb_out = cb_q;
  assign Cr_out = cr_q;

endmodule

// File: doc/yc2ycbcr.md
Name: yc2ycbcr

Overview:
- Converts a 4:2:2 YC stream back to 4:4:4 YCbCr.
- Input carries full-rate Y plus one chroma word per pixel. Within each active run, the chroma word alternates Cb, Cr, Cb, Cr, …
- Each Cb/Cr pair is rebuilt by chroma replication and presented on both pixels of the pair.
- Sits on the receive side of the YC link, before the YCbCr-to-RGB conversion path. Fixed 2-cycle pipeline; syncs are delayed to match.

Parameters:
- C_DATA_WIDTH, 10, width of Y, C, Cb and Cr samples.
- C_CR_FIRST, 0. 0: first chroma word of each DE run is Cb. 1: first chroma word is Cr.

Ports:
- clk  in  1  pixel clock; all registers on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- VS_in  in  1  vertical sync.
- HS_in  in  1  horizontal sync.
- DE_in  in  1  data enable; high during active pixels.
- Y_in  in  C_DATA_WIDTH  luma.
- C_in  in  C_DATA_WIDTH  multiplexed chroma.
- VS_out  out  1  VS_in delayed 2 clocks.
- HS_out  out  1  HS_in delayed 2 clocks.
- DE_out  out  1  DE_in delayed 2 clocks.
- Y_out  out  C_DATA_WIDTH  Y_in delayed 2 clocks.
- Cb_out  out  C_DATA_WIDTH  reconstructed Cb.
- Cr_out  out  C_DATA_WIDTH  reconstructed Cr.

Behaviour:
- Reset (reset=0, asynchronous): VS_out=1, HS_out=1, DE_out=0, Y_out=0, Cb_out=0, Cr_out=0.
  - All internal stage registers, the phase bit and chroma hold registers clear to 0.
  - Reset mid-line abandons the current pair. The first DE cycle after release restarts at phase 0.
- Phase bit ph:
  - While DE_in=1, ph toggles each clock. When DE_in=0, ph is cleared.
  - So the first active sample of every run has ph=0.
  - ph=0 is Cb when C_CR_FIRST=0, Cr when C_CR_FIRST=1. Below, "first" means the ph=0 chroma type and "second" the other.
- Stage A registers each input cycle: VS, HS, DE, Y, C and ph.
- Output register, driven from stage A and the current input (one-pixel look-ahead). VS, HS, DE and Y pass through from stage A.
  - Stage A DE=1, ph=0:
    - First-chroma output = C_a.
    - Second-chroma output = C_in, if DE_in=1 (the paired sample is arriving).
    - Otherwise (odd-length run, trailing pixel) second-chroma output = neutral value 1<<(C_DATA_WIDTH-1), i.e. 512 at W=10.
    - C_a is latched into the hold register.
  - Stage A DE=1, ph=1:
    - Second-chroma output = C_a.
    - First-chroma output = hold register (the pair's first sample).
  - Stage A DE=0: Cb_out = Cr_out = C_a (blanking chroma passed unchanged). Hold register is not updated.
- Latency: exactly 2 clocks from input to output for every signal, active or blanking. No back-pressure, no stalls; throughput one pixel per clock.
- DE toggling:
  - A DE gap of any length, including one cycle, ends the run. The next run restarts at ph=0.
  - The look-ahead never pairs samples across a gap.
- Single-cycle DE run (one pixel): output is first chroma = C, second chroma = neutral.
- No arithmetic beyond selection. All values are passed bit-exact; no rounding or clipping.

Test Plan:
- Reset then idle: hold reset=0 with random inputs -> VS_out=HS_out=1, DE_out=0, Y/Cb/Cr_out=0. After release, outputs track inputs with 2-cycle delay.
- Even run, C_CR_FIRST=0: DE high 4 cycles, Y=100,101,102,103, C=200(Cb),300(Cr),201,301 -> 2 cycles later DE_out high 4 cycles:
  - Y_out 100..103
  - Cb_out 200,200,201,201
  - Cr_out 300,300,301,301
- Odd run: DE high 3 cycles, C=200,300,201 -> Cb_out 200,200,201; Cr_out 300,300,512.
- Gap restart: run C=200,300,201, DE low 1 cycle, run C=400,500 -> second run output Cb 400,400, Cr 500,500. Phase restarts; no cross-gap pairing (third pixel of first run Cr=512).
- C_CR_FIRST=1: DE high 2 cycles, C=300,200 -> Cr_out 300,300; Cb_out 200,200.
- Reset mid-line: assert reset after pixel 1 of a 4-pixel run -> outputs go to reset values immediately. A new run after release starts pairing at its first sample with correct Cb/Cr.
